// File: rtl/bus_rr_arbiter_if.sv
// Bundle of request, data and completion signals for the two-master
// round-robin bus arbiter. The arbiter uses the slave view; the masters
// and the bus destination together use the master view.
interface bus_rr_arbiter_if #(
  parameter int N = 8
);
  logic         req_1;
  logic         req_2;
  logic [N-1:0] data_in_1;
  logic [N-1:0] data_in_2;
  logic         bus_ready;
  logic [N-1:0] bus;
  logic         bus_valid;
  logic         select;
  logic         ack_1;
  logic         ack_2;

  modport master (
    output req_1, req_2, data_in_1, data_in_2, bus_ready,
    input  bus, bus_valid, select, ack_1, ack_2
  );

  modport slave (
    input  req_1, req_2, data_in_1, data_in_2, bus_ready,
    output bus, bus_valid, select, ack_1, ack_2
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin bus arbiter. Grants one requester, registers its
// word onto the shared bus, waits for the destination's ready and then
// returns a one-cycle acknowledge. All outputs come straight from flops.
module bus_rr_arbiter #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  bus_rr_arbiter_if.slave  bif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Registered state and outputs
  logic [1:0]   r_state;
  logic [N-1:0] r_bus;
  logic         r_valid;
  logic         r_select;
  logic         r_ack_1;
  logic         r_ack_2;
  logic         r_last;     // 0 = master 1 served last, 1 = master 2

  // Next-state values
  logic [1:0]   w_state;
  logic [N-1:0] w_bus;
  logic         w_valid;
  logic         w_select;
  logic         w_ack_1;
  logic         w_ack_2;
  logic         w_last;

  // Arbitration result
  logic         w_req_any;
  logic         w_grant;    // 0 = master 1, 1 = master 2

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    w_req_any = bif.req_1 | bif.req_2;
    w_grant   = 1'b0;
    if (bif.req_1 && bif.req_2) begin
      w_grant = ~r_last;
    end else if (bif.req_2) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  // Transfer sequencing: IDLE grants, BUSY waits for ready, ACK pulses for one cycle
  always_comb begin
    w_state  = r_state;
    w_bus    = r_bus;
    w_valid  = r_valid;
    w_select = r_select;
    w_ack_1  = r_ack_1;
    w_ack_2  = r_ack_2;
    w_last   = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_bus    = w_grant ? bif.data_in_2 : bif.data_in_1;
          w_valid  = 1'b1;
          w_select = w_grant;
          w_state  = ST_BUSY;
        end else begin
          w_state  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Word was latched at grant; requests and data_in are ignored here
        if (bif.bus_ready) begin
          w_valid = 1'b0;
          w_bus   = '0;
          w_ack_1 = ~r_select;
          w_ack_2 = r_select;
          w_last  = r_select;
          w_state = ST_ACK;
        end else begin
          w_state = ST_BUSY;
        end
      end
      ST_ACK: begin
        w_ack_1 = 1'b0;
        w_ack_2 = 1'b0;
        w_state = ST_IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to a quiet idle bus
        w_bus   = '0;
        w_valid = 1'b0;
        w_ack_1 = 1'b0;
        w_ack_2 = 1'b0;
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bus    <= '0;
      r_valid  <= 1'b0;
      r_select <= 1'b0;
      r_ack_1  <= 1'b0;
      r_ack_2  <= 1'b0;
      r_last   <= 1'b1;   // master 1 wins the first tie
    end else begin
      r_state  <= w_state;
      r_bus    <= w_bus;
      r_valid  <= w_valid;
      r_select <= w_select;
      r_ack_1  <= w_ack_1;
      r_ack_2  <= w_ack_2;
      r_last   <= w_last;
    end
  end

  assign bif.bus       = r_bus;
  assign bif.bus_valid = r_valid;
  assign bif.select    = r_select;
  assign bif.ack_1     = r_ack_1;
  assign bif.ack_2     = r_ack_2;

endmodule
